// File: rtl/mac_sequencer.sv
// mac_sequencer: drives an 8-bit MAC through a dot product of N operand
// pairs and reads the 2W-bit accumulator back as MSW then LSW.
module mac_sequencer #(
    parameter int         DATA_WIDTH = 8,
    parameter int         LEN_WIDTH  = 8,
    parameter logic [3:0] NOP_OPCODE = 4'hF
) (
    input  logic                    clk,
    input  logic                    a_reset_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    length,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    input  logic                    op_valid,
    output logic                    op_ready,
    output logic [3:0]              mac_opcode,
    output logic [DATA_WIDTH-1:0]   mac_data_in,
    input  logic [DATA_WIDTH-1:0]   mac_data_out,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    busy
);

    localparam logic [3:0] MAC_RESET = 4'h0;
    localparam logic [3:0] MAC_REGA  = 4'h1;
    localparam logic [3:0] MAC_REGB  = 4'h2;
    localparam logic [3:0] MAC_MULT  = 4'h3;
    localparam logic [3:0] MAC_ACC   = 4'h4;
    localparam logic [3:0] MAC_MSW   = 4'h5;
    localparam logic [3:0] MAC_LSW   = 4'h6;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        FETCH,
        LOAD_A,
        LOAD_B,
        MULT,
        ACC,
        READ_MSW,
        READ_LSW,
        CAPTURE,
        DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [LEN_WIDTH-1:0]    count;
    logic [DATA_WIDTH-1:0]   a_hold;
    logic [DATA_WIDTH-1:0]   b_hold;

    // State register
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pair counter, operand holding flops and result assembly
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            count  <= '0;
            a_hold <= '0;
            b_hold <= '0;
            result <= '0;
        end else begin
            if (state == IDLE && start) begin
                count <= length;
            end
            if (state == ACC) begin
                count <= count - LEN_WIDTH'(1);
            end
            if (state == FETCH && op_valid) begin
                a_hold <= op_a;
                b_hold <= op_b;
            end
            // MSW is on data_out during READ_LSW, LSW during CAPTURE
            if (state == READ_LSW) begin
                result[2*DATA_WIDTH-1:DATA_WIDTH] <= mac_data_out;
            end
            if (state == CAPTURE) begin
                result[DATA_WIDTH-1:0] <= mac_data_out;
            end
        end
    end

    // Next state; abort overrides every transition outside IDLE
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (start) next_state = CLEAR;
            CLEAR:    next_state = (count != '0) ? FETCH : READ_MSW;
            FETCH:    if (op_valid) next_state = LOAD_A;
            LOAD_A:   next_state = LOAD_B;
            LOAD_B:   next_state = MULT;
            MULT:     next_state = ACC;
            ACC: begin
                if (count == LEN_WIDTH'(1)) begin
                    next_state = READ_MSW;
                end else begin
                    next_state = FETCH;
                end
            end
            READ_MSW: next_state = READ_LSW;
            READ_LSW: next_state = CAPTURE;
            CAPTURE:  next_state = DONE;
            DONE:     if (result_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (abort && state != IDLE) begin
            next_state = IDLE;
        end
    end

    // Outputs decoded from state and holding flops only
    always_comb begin
        mac_opcode   = NOP_OPCODE;
        mac_data_in  = '0;
        op_ready     = 1'b0;
        result_valid = 1'b0;
        busy         = (state != IDLE);
        unique case (state)
            CLEAR:    mac_opcode = MAC_RESET;
            FETCH:    op_ready = 1'b1;
            LOAD_A: begin
                mac_opcode  = MAC_REGA;
                mac_data_in = a_hold;
            end
            LOAD_B: begin
                mac_opcode  = MAC_REGB;
                mac_data_in = b_hold;
            end
            MULT:     mac_opcode = MAC_MULT;
            ACC:      mac_opcode = MAC_ACC;
            READ_MSW: mac_opcode = MAC_MSW;
            READ_LSW: mac_opcode = MAC_LSW;
            DONE:     result_valid = 1'b1;
            default: begin
                mac_opcode = NOP_OPCODE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed vectors against a behavioural MAC model.
// Cycle numbers count the start-accepting edge as cycle 0.
module tb_mac_sequencer;

    localparam logic [3:0] OP_RESET = 4'h0;
    localparam logic [3:0] OP_REGA  = 4'h1;
    localparam logic [3:0] OP_REGB  = 4'h2;
    localparam logic [3:0] OP_MULT  = 4'h3;
    localparam logic [3:0] OP_ACC   = 4'h4;
    localparam logic [3:0] OP_MSW   = 4'h5;
    localparam logic [3:0] OP_LSW   = 4'h6;
    localparam logic [3:0] OP_NOP   = 4'hF;

    logic        clk = 1'b0;
    logic        a_reset_n;
    logic        start;
    logic [7:0]  length;
    logic        abort;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  mac_opcode;
    logic [7:0]  mac_data_in;
    logic [7:0]  mac_data_out;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] va [8];
    logic [7:0] vb [8];
    int         stall [8];
    logic [3:0] otr [64];
    logic [7:0] dtr [64];
    bit         saw_ready;

    always #5 clk = ~clk;

    mac_sequencer #(
        .DATA_WIDTH(8),
        .LEN_WIDTH(8),
        .NOP_OPCODE(4'hF)
    ) dut (
        .clk(clk),
        .a_reset_n(a_reset_n),
        .start(start),
        .length(length),
        .abort(abort),
        .op_a(op_a),
        .op_b(op_b),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .mac_opcode(mac_opcode),
        .mac_data_in(mac_data_in),
        .mac_data_out(mac_data_out),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy(busy)
    );

    // Behavioural MAC: registered byte-wide readback of the accumulator
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;
    logic [7:0]  m_out = '0;
    logic [15:0] m_prod = '0;
    logic [15:0] m_acc = '0;

    always @(posedge clk) begin
        case (mac_opcode)
            OP_RESET: begin
                m_acc  <= '0;
                m_prod <= '0;
            end
            OP_REGA: m_a <= mac_data_in;
            OP_REGB: m_b <= mac_data_in;
            OP_MULT: m_prod <= 16'(m_a) * 16'(m_b);
            OP_ACC:  m_acc <= m_acc + m_prod;
            OP_MSW:  m_out <= m_acc[15:8];
            OP_LSW:  m_out <= m_acc[7:0];
            default: ;
        endcase
    end

    assign mac_data_out = m_out;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start an N-pair run and drive operands until result_valid or abort
    task automatic run(input int n, input int pulse_c, input int abort_c,
                       output int vcyc);
        int  cyc;
        int  k;
        bit  fin;
        cyc = 0;
        k = 0;
        fin = 0;
        vcyc = -1;
        saw_ready = 0;
        @(negedge clk);
        start = 1'b1;
        length = n[7:0];
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_c);
            if (cyc == pulse_c) length = 8'd9;
            if (cyc < 64) begin
                otr[cyc] = mac_opcode;
                dtr[cyc] = mac_data_in;
            end
            if (op_ready) saw_ready = 1;
            if (abort) begin
                abort = 1'b0;
                op_valid = 1'b0;
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_rv", {31'd0, result_valid}, 32'd0);
                fin = 1;
            end else if (result_valid) begin
                vcyc = cyc;
                op_valid = 1'b0;
                fin = 1;
            end else if (cyc > 300) begin
                chk("timeout", 32'd1, 32'd0);
                op_valid = 1'b0;
                fin = 1;
            end else begin
                if (cyc == abort_c) abort = 1'b1;
                if (k < n) begin
                    op_a = va[k];
                    op_b = vb[k];
                    op_valid = (stall[k] == 0);
                    if (op_ready) begin
                        if (op_valid) k++;
                        else stall[k]--;
                    end
                end else begin
                    op_valid = 1'b0;
                end
            end
        end
        start = 1'b0;
    endtask

    // Check the held result, then complete the output handshake
    task automatic take(input logic [15:0] expv);
        chk("result", {16'd0, result}, {16'd0, expv});
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        chk("rv_drop", {31'd0, result_valid}, 32'd0);
        chk("busy_drop", {31'd0, busy}, 32'd0);
        chk("result_hold", {16'd0, result}, {16'd0, expv});
    endtask

    initial begin
        int vc;
        logic [3:0] eo;
        logic [7:0] ed;
        logic [3:0] seq [5];
        seq[0] = OP_NOP;
        seq[1] = OP_REGA;
        seq[2] = OP_REGB;
        seq[3] = OP_MULT;
        seq[4] = OP_ACC;
        for (int i = 0; i < 8; i++) begin
            va[i] = '0;
            vb[i] = '0;
            stall[i] = 0;
        end
        a_reset_n = 1'b0;
        start = 1'b0;
        length = '0;
        abort = 1'b0;
        op_a = '0;
        op_b = '0;
        op_valid = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        a_reset_n = 1'b1;
        @(negedge clk);
        chk("rst_opcode", {28'd0, mac_opcode}, {28'd0, OP_NOP});
        chk("rst_din", {24'd0, mac_data_in}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // abort in IDLE does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort", {31'd0, busy}, 32'd0);

        // N=3 with op_valid held high, full opcode/data trace
        va[0] = 8'd2;  vb[0] = 8'd3;
        va[1] = 8'd4;  vb[1] = 8'd5;
        va[2] = 8'd10; vb[2] = 8'd20;
        run(3, -1, -1, vc);
        chk("n3_cycle", vc, 32'd20);
        take(16'h00E2);
        for (int c = 1; c <= 19; c++) begin
            ed = 8'd0;
            if (c == 1) eo = OP_RESET;
            else if (c == 17) eo = OP_MSW;
            else if (c == 18) eo = OP_LSW;
            else if (c == 19) eo = OP_NOP;
            else begin
                eo = seq[(c - 2) % 5];
                if ((c - 2) % 5 == 1) ed = va[(c - 2) / 5];
                if ((c - 2) % 5 == 2) ed = vb[(c - 2) / 5];
            end
            chk($sformatf("n3_op%0d", c), {28'd0, otr[c]}, {28'd0, eo});
            chk($sformatf("n3_din%0d", c), {24'd0, dtr[c]}, {24'd0, ed});
        end

        // Wrap-around of the 16-bit accumulator
        va[0] = 8'd255; vb[0] = 8'd255;
        va[1] = 8'd255; vb[1] = 8'd255;
        run(2, -1, -1, vc);
        chk("wrap_cycle", vc, 32'd15);
        take(16'hFC02);

        // N=0: cleared accumulator read back, no operand handshake
        run(0, -1, -1, vc);
        chk("n0_cycle", vc, 32'd5);
        chk("n0_no_ready", {31'd0, saw_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("n0_rv_held", {31'd0, result_valid}, 32'd1);
            chk("n0_res_held", {16'd0, result}, 32'd0);
        end
        take(16'h0000);

        // Stall before pair 1; start and length pulsed while busy
        va[0] = 8'd3; vb[0] = 8'd7;
        va[1] = 8'd1; vb[1] = 8'd1;
        stall[1] = 3;
        run(2, 6, -1, vc);
        chk("stall_cycle", vc, 32'd18);
        take(16'h0016);
        @(negedge clk);
        chk("stall_idle", {31'd0, busy}, 32'd0);

        // Abort in ACC of pair 1, then a clean N=1 run
        va[0] = 8'd5; vb[0] = 8'd5;
        va[1] = 8'd9; vb[1] = 8'd9;
        run(2, -1, 11, vc);
        chk("abort_keep", {16'd0, result}, 32'h0016);
        va[0] = 8'd2; vb[0] = 8'd2;
        run(1, -1, -1, vc);
        chk("post_abort_cycle", vc, 32'd10);
        take(16'h0004);

        // Asynchronous reset while in MULT of pair 0
        va[0] = 8'd7; vb[0] = 8'd7;
        @(negedge clk);
        start = 1'b1;
        length = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_a = 8'd7;
        op_b = 8'd7;
        op_valid = 1'b1;
        repeat (4) @(negedge clk);
        op_valid = 1'b0;
        chk("mid_mult", {28'd0, mac_opcode}, {28'd0, OP_MULT});
        #2 a_reset_n = 1'b0;
        #1;
        chk("arst_opcode", {28'd0, mac_opcode}, {28'd0, OP_NOP});
        chk("arst_din", {24'd0, mac_data_in}, 32'd0);
        chk("arst_result", {16'd0, result}, 32'd0);
        chk("arst_rv", {31'd0, result_valid}, 32'd0);
        chk("arst_ready", {31'd0, op_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        a_reset_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control stage directly upstream of the 8-bit MAC unit. It accepts a stream of operand pairs over a valid/ready handshake and drives the MAC's `opcode` and `data_in` ports to compute a dot product of length N. It reads the 2·DATA_WIDTH accumulator back through the MAC's byte-wide `data_out`, using the MSW then LSW read opcodes. It presents the assembled result on a held valid/ready output.

## Interface
- `DATA_WIDTH`, 8: operand width; must match the MAC instance.
- `LEN_WIDTH`, 8: width of the vector-length input.
- `NOP_OPCODE`, 4'hF: idle opcode; must differ from every MAC_* encoding in `sap1_header.vh`.

- `clk`  in  1  single clock, rising edge.
- `a_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a dot product; sampled only in IDLE.
- `length`  in  LEN_WIDTH  number of pairs N, latched on accepted `start`.
- `abort`  in  1  cancel the run in progress.
- `op_a`, `op_b`  in  DATA_WIDTH each  operand pair.
- `op_valid`  in  1  operand pair valid.
- `op_ready`  out  1  sequencer accepts the pair this cycle.
- `mac_opcode`  out  4  to MAC `opcode`.
- `mac_data_in`  out  DATA_WIDTH  to MAC `data_in`.
- `mac_data_out`  in  DATA_WIDTH  from MAC `data_out`.
- `result`  out  2·DATA_WIDTH  dot-product result.
- `result_valid`  out  1  result available; held until accepted.
- `result_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Outputs are decoded from state and holding flops only. There is no combinational path from any input to any output.
- States and the outputs each state drives:
  - IDLE: `NOP_OPCODE`.
  - CLEAR: `MAC_RESET`.
  - FETCH: `NOP_OPCODE`, `op_ready`=1.
  - LOAD_A: `MAC_REGA`, `mac_data_in`=a_hold.
  - LOAD_B: `MAC_REGB`, `mac_data_in`=b_hold.
  - MULT: `MAC_MULT`.
  - ACC: `MAC_ACC`.
  - READ_MSW: `MAC_MSW`.
  - READ_LSW: `MAC_LSW`.
  - CAPTURE: `NOP_OPCODE`.
  - DONE: `result_valid`=1.
- `mac_data_in` is 0 in every state except LOAD_A and LOAD_B.
- State transitions:
  - IDLE→CLEAR on `start`; `length` is latched into the counter.
  - CLEAR→FETCH if count≠0, otherwise CLEAR→READ_MSW.
  - FETCH holds until `op_valid`. On the handshake, `op_a`/`op_b` are latched into a_hold/b_hold and the state moves to LOAD_A.
  - LOAD_A→LOAD_B→MULT→ACC.
  - ACC decrements the count, then goes to READ_MSW if the new count is 0, otherwise back to FETCH.
  - READ_MSW→READ_LSW→CAPTURE→DONE.
  - DONE→IDLE on `result_ready`.
- Result capture:
  - `mac_data_out` is sampled at the end of READ_LSW into `result[2W-1:W]`. This is the MSW, made visible by the previous cycle's MAC_MSW.
  - `mac_data_out` is sampled at the end of CAPTURE into `result[W-1:0]` (the LSW).
- Arithmetic: result = Σ a_i·b_i mod 2^(2·DATA_WIDTH). Wrap-around happens in the MAC accumulator and is not flagged. N ranges over 0..2^LEN_WIDTH−1.
- Edge cases:
  - N=0: the accumulator is still cleared and read back, so `result`=0. `op_ready` never asserts.
  - `start` while `busy`: ignored. `length` changes while busy have no effect.
  - `abort` in any non-IDLE state: next state is IDLE. `result_valid` drops and `op_ready` drops. The MAC accumulator is left as is; the next run's CLEAR removes it. `abort` takes priority over every other transition, including DONE with `result_ready`. `abort` in IDLE has no effect.
  - `result` holds its value after the handshake until the next CAPTURE overwrites it.

## Timing
- Reset values: IDLE, `mac_opcode`=NOP_OPCODE, `mac_data_in`=0, `result`=0, `result_valid`=0, `op_ready`=0, `busy`=0, count=0, a_hold=b_hold=0.
- Reset asserted mid-run returns to these values immediately. No partial result is presented.
- Let cycle 0 be the edge at which `start` is accepted. With `op_valid` held high:
  - CLEAR is in cycle 1.
  - Pair k (k=0..N−1) occupies cycles 2+5k..6+5k: FETCH, LOAD_A, LOAD_B, MULT, ACC.
  - READ_MSW, READ_LSW, CAPTURE occupy cycles 2+5N..4+5N.
  - `result_valid` first rises in cycle 5+5N.
- Each FETCH cycle without `op_valid` adds exactly one cycle.
- Maximum throughput is one operand pair per 5 cycles. `op_ready` is high only in FETCH.
- DONE→IDLE takes 1 cycle, so the earliest next `start` is sampled in the cycle after the handshake.

## Test plan
- Reset: assert `a_reset_n`=0 mid-run (in MULT) → all outputs return to their reset values without waiting for a clock edge; `mac_opcode`=4'hF.
- N=3 with pairs (2,3), (4,5), (10,20) and `op_valid` held high → `result`=16'h00E2, `result_valid` high at cycle 20; opcode trace RESET, then (NOP, REGA, REGB, MULT, ACC)×3, then MSW, LSW, NOP.
- Wrap: N=2 with pairs (255,255), (255,255) → `result`=16'hFC02.
- N=0 → `result`=16'h0000 at cycle 5, `op_ready` never high. Hold `result_ready` low for 4 cycles → `result_valid` and `result` stay stable.
- Stall and ignored start: N=2 (3,7), (1,1) with `op_valid` low for 3 cycles before the second pair → `result`=16'h0016 at cycle 18. A `start` pulsed at cycle 6 has no effect.
- Abort at ACC of pair 1 (with (9,9) pending), then a new run N=1 (2,2) → `busy` low 1 cycle after `abort`; second run gives `result`=16'h0004, with no leftover sum from the aborted run.
